// File: rtl/keypad_pkg.sv
// Shared constants for the 4x3 keypad emulator: FSM encodings, key-to-row/column
// lookup tables and the bounce LFSR tap mask.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;
  localparam logic [3:0] KEY_MAX = 4'd11;

  typedef logic [1:0] state_t;
  localparam state_t IDLE    = 2'd0;
  localparam state_t PRESS_B = 2'd1;
  localparam state_t HELD    = 2'd2;
  localparam state_t REL_B   = 2'd3;

  // Two bits per key code, code 0 in the least-significant slot.
  //                             11     10     9      8      7      6      5      4      3      2      1      0
  localparam logic [23:0] KEY_ROW = {2'd3, 2'd3, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd3};
  localparam logic [23:0] KEY_COL = {2'd2, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd1};

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [1:0] key_row(input logic [3:0] code);
    int idx;
    idx = (code > KEY_MAX) ? 0 : int'(code);
    return KEY_ROW[idx*2 +: 2];
  endfunction

  function automatic logic [1:0] key_col(input logic [3:0] code);
    int idx;
    idx = (code > KEY_MAX) ? 0 : int'(code);
    return KEY_COL[idx*2 +: 2];
  endfunction

endpackage

// File: rtl/keypad_lfsr.sv
// 16-bit Galois LFSR supplying pseudo-random contact chatter during bounce phases.
module keypad_lfsr
  import keypad_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        en,
  input  logic [15:0] seed,
  output logic        out
);

  logic [15:0] lfsr_reg;
  logic [15:0] lfsr_next;

  always_comb begin
    lfsr_next = {1'b0, lfsr_reg[15:1]};
    if (lfsr_reg[0]) begin
      lfsr_next = lfsr_next ^ LFSR_TAPS;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      lfsr_reg <= seed;
    end else if (en) begin
      lfsr_reg <= lfsr_next;
    end
  end

  assign out = lfsr_reg[0];

endmodule

// File: rtl/keypad_emulator.sv
// 4x3 telephone keypad model: plays a press-bounce / hold / release-bounce contact
// sequence per host command. KEYPAD_EMU_BOUNCE_EN enables LFSR chatter in bounce phases.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int          BOUNCE_CYC = 16,
  parameter int          HOLD_CYC   = 64,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NUM_COLS-1:0] C,
  output logic [NUM_ROWS-1:0] R,
  input  logic                cmd_valid,
  input  logic [3:0]          cmd_key,
  output logic                cmd_ready,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int MAX_CYC = (BOUNCE_CYC > HOLD_CYC) ? BOUNCE_CYC : HOLD_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYC - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       row_reg, col_reg;
  logic             contact_reg, contact_next;
  logic             done_reg, err_reg;
  logic             accept, key_ok, lfsr_en, lfsr_bit, col_hit;

  assign accept  = cmd_valid && (state_reg == IDLE);
  assign key_ok  = (cmd_key <= KEY_MAX);
  assign lfsr_en = (state_reg == PRESS_B) || (state_reg == REL_B);

`ifdef KEYPAD_EMU_BOUNCE_EN
  keypad_lfsr u_lfsr (
    .CLK  (CLK),
    .RST  (RST),
    .en   (lfsr_en),
    .seed (LFSR_SEED),
    .out  (lfsr_bit)
  );
`else
  // Without chatter the press phase reads closed and the release phase reads open.
  logic unused_bounce;
  assign unused_bounce = ^LFSR_SEED ^ lfsr_en;
  assign lfsr_bit      = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept && key_ok) begin
          state_next = PRESS_B;
          cnt_next   = BOUNCE_LOAD;
        end
      end
      PRESS_B: begin
        if (cnt_reg == '0) begin
          state_next = HELD;
          cnt_next   = HOLD_LOAD;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      HELD: begin
        if (cnt_reg == '0) begin
          state_next = REL_B;
          cnt_next   = BOUNCE_LOAD;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: begin
        if (cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
    endcase
  end

  // Contact is registered against the state being entered, so R never glitches on FSM changes.
  always_comb begin
    contact_next = 1'b0;
    case (state_next)
`ifdef KEYPAD_EMU_BOUNCE_EN
      PRESS_B: contact_next = lfsr_bit;
      REL_B:   contact_next = lfsr_bit;
`else
      PRESS_B: contact_next = 1'b1 | lfsr_bit;
      REL_B:   contact_next = 1'b0 & lfsr_bit;
`endif
      HELD:    contact_next = 1'b1;
      default: contact_next = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      row_reg     <= '0;
      col_reg     <= '0;
      contact_reg <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      contact_reg <= contact_next;
      done_reg    <= (state_reg == REL_B) && (state_next == IDLE);
      err_reg     <= accept && !key_ok;
      if (accept && key_ok) begin
        row_reg <= key_row(cmd_key);
        col_reg <= key_col(cmd_key);
      end
    end
  end

  always_comb begin
    col_hit = 1'b0;
    case (col_reg)
      2'd0:    col_hit = C[0];
      2'd1:    col_hit = C[1];
      2'd2:    col_hit = C[2];
      default: col_hit = 1'b0;
    endcase
  end

  for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
    assign R[gi] = contact_reg && col_hit && (row_reg == 2'(gi));
  end

  assign cmd_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator with BOUNCE_CYC=4, HOLD_CYC=8.
module tb_keypad_emulator;

  localparam int BC = 4;
  localparam int HC = 8;
  localparam int SEQ = 2*BC + HC;

  logic       CLK = 1'b0;
  logic       RST;
  logic [2:0] C;
  logic [3:0] R;
  logic       cmd_valid;
  logic [3:0] cmd_key;
  logic       cmd_ready, busy, done, err;

  int vectors = 0;
  int miscompares = 0;

  keypad_emulator #(.BOUNCE_CYC(BC), .HOLD_CYC(HC), .LFSR_SEED(16'hACE1)) dut (
    .CLK(CLK), .RST(RST), .C(C), .R(R),
    .cmd_valid(cmd_valid), .cmd_key(cmd_key),
    .cmd_ready(cmd_ready), .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, want);
    end
  endtask

  // Issues one key press, walks the whole busy window and stops in the done cycle.
  task automatic press_seq(input logic [3:0] key, input logic [2:0] cpos, input logic [3:0] rexp,
                           input logic [2:0] cneg, input bit inject);
    logic [3:0] held_r;
    cmd_valid = 1'b1;
    cmd_key   = key;
    tick();
    cmd_valid = 1'b0;
    held_r    = 4'b0000;
    for (int k = 0; k < SEQ; k++) begin
      check($sformatf("busy k%0d", k), {3'b0, busy}, 4'b0001);
      check($sformatf("done k%0d", k), {3'b0, done}, 4'b0000);
`ifndef KEYPAD_EMU_BOUNCE_EN
      if (k == 0) begin
        C = cpos; #1;
        check($sformatf("press_r key%0d", key), R, rexp);
      end
      if (k == BC + HC + 1) begin
        C = cpos; #1;
        check($sformatf("rel_r key%0d", key), R, 4'b0000);
      end
`endif
      if (k == BC + 2) begin
        C = cpos; #1;
        check($sformatf("held_r key%0d", key), R, rexp);
        held_r = R;
        C = cneg; #1;
        check($sformatf("held_rneg key%0d", key), R, 4'b0000);
        C = cpos; #1;
      end
      if (k == BC + 5) begin
        check($sformatf("held_stable key%0d", key), R, held_r);
      end
      if (inject && k == 5) begin
        cmd_valid = 1'b1;
        cmd_key   = 4'd3;
      end
      tick();
      cmd_valid = 1'b0;
    end
    check($sformatf("done_pulse key%0d", key), {3'b0, done}, 4'b0001);
    check($sformatf("busy_end key%0d", key), {3'b0, busy}, 4'b0000);
    check($sformatf("ready_end key%0d", key), {3'b0, cmd_ready}, 4'b0001);
  endtask

  initial begin
    RST = 1'b1; C = 3'b000; cmd_valid = 1'b0; cmd_key = 4'd0;
    tick();
    tick();
    RST = 1'b0;
    check("rst_r", R, 4'b0000);
    check("rst_ready", {3'b0, cmd_ready}, 4'b0001);
    check("rst_busy", {3'b0, busy}, 4'b0000);
    check("rst_done", {3'b0, done}, 4'b0000);
    check("rst_err", {3'b0, err}, 4'b0000);

    // Key 5: row 1, column 1.
    press_seq(4'd5, 3'b010, 4'b0010, 3'b001, 1'b0);
    tick();
    check("done_clear5", {3'b0, done}, 4'b0000);

    // Key 0 with all columns high, and a command injected mid-sequence.
    press_seq(4'd0, 3'b111, 4'b1000, 3'b000, 1'b1);
    // Key 11 accepted straight from the done cycle of the previous press.
    press_seq(4'd11, 3'b100, 4'b1000, 3'b011, 1'b0);
    for (int i = 0; i < 2*SEQ; i++) begin
      tick();
      check($sformatf("no_second_done c%0d", i), {2'b0, busy, done}, 4'b0000);
    end

    // Invalid key code.
    C = 3'b111;
    cmd_valid = 1'b1; cmd_key = 4'd13;
    tick();
    cmd_valid = 1'b0;
    check("err_pulse", {3'b0, err}, 4'b0001);
    check("err_busy", {3'b0, busy}, 4'b0000);
    check("err_r", R, 4'b0000);
    check("err_ready", {3'b0, cmd_ready}, 4'b0001);
    tick();
    check("err_clear", {3'b0, err}, 4'b0000);
    check("err_busy2", {3'b0, busy}, 4'b0000);

    // Reset in the middle of HELD.
    C = 3'b010;
    cmd_valid = 1'b1; cmd_key = 4'd5;
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < BC + 2; k++) tick();
    check("abort_held_r", R, 4'b0010);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("abort_r", R, 4'b0000);
    check("abort_busy", {3'b0, busy}, 4'b0000);
    check("abort_ready", {3'b0, cmd_ready}, 4'b0001);
    for (int i = 0; i < SEQ + 4; i++) begin
      check($sformatf("abort_nodone c%0d", i), {2'b0, busy, done}, 4'b0000);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
Synthesizable 4x3 telephone-keypad model that answers the keypad scanner's column strobes with row levels. It is used for hardware-in-loop checks of the scanner and as the keypad stand-in on boards without a physical keypad. A host issues one key-press command. The block then plays out a timed contact sequence: press bounce, stable hold, release bounce. While the contact is closed, it drives the row line of the selected key whenever that key's column is high.

Parameters:
- BOUNCE_CYC, 16, clock cycles in each bounce phase (press and release); must be >= 1.
- HOLD_CYC, 64, clock cycles of stable contact closure; must be >= 1.
- LFSR_SEED, 16'hACE1, non-zero reset value of the bounce LFSR.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous reset, active high.
- C  input  3  column lines from the scanner (C[0]=C0 .. C[2]=C2), active high.
- R  output  4  row lines to the scanner (R[0]=R0 .. R[3]=R3), active high.
- cmd_valid  input  1  host presents a key command.
- cmd_key  input  4  key code, valid 0..11.
- cmd_ready  output  1  block can accept a command.
- busy  output  1  a press sequence is in progress.
- done  output  1  one-cycle pulse when the sequence completes.
- err  output  1  one-cycle pulse when an invalid key code is rejected.

Behaviour:
- Reset: one clock, synchronous and active-high (CLK/RST).
  - While RST is high at a rising edge: state=IDLE, contact=0, counter=0, LFSR=LFSR_SEED, stored key cleared.
  - Outputs after that edge: R=0, cmd_ready=1, busy=0, done=0, err=0.
  - Reset in any non-IDLE state aborts the sequence; R=0 from the following cycle and done does not pulse.
- Key map (code -> row,col):
  - 1 -> 0,0; 2 -> 0,1; 3 -> 0,2
  - 4 -> 1,0; 5 -> 1,1; 6 -> 1,2
  - 7 -> 2,0; 8 -> 2,1; 9 -> 2,2
  - 10 (*) -> 3,0; 0 -> 3,1; 11 (#) -> 3,2
- Row output (combinational from registered state):
  - R[row] = contact & C[col]; all other R bits are 0.
  - Multiple C bits high (the scanner's all-columns phase) still drive only R[row] when C[col]=1.
- Handshake:
  - cmd_ready = (state==IDLE).
  - Accept occurs on an edge where cmd_valid & cmd_ready.
  - cmd_valid while busy is ignored and not queued.
  - cmd_key 12..15 on an accept edge: err pulses on the next cycle, state stays IDLE, cmd_ready stays 1.
- FSM (states IDLE, PRESS_B, HELD, REL_B):
  - IDLE: on a valid accept, latch row/col, load counter=BOUNCE_CYC-1 and go to PRESS_B.
  - PRESS_B: contact = LFSR bit0 each cycle. When the counter reaches 0, go to HELD with counter=HOLD_CYC-1.
  - HELD: contact=1. When the counter reaches 0, go to REL_B with counter=BOUNCE_CYC-1.
  - REL_B: contact = LFSR bit0. When the counter reaches 0, go to IDLE and force contact=0.
  - done pulses in the first IDLE cycle after REL_B.
- Timing:
  - Accept at edge t gives busy=1 for exactly 2*BOUNCE_CYC+HOLD_CYC cycles starting t+1.
  - done=1 in cycle t+1+2*BOUNCE_CYC+HOLD_CYC.
  - A new command may be accepted in the done cycle.
- Counter width: $clog2(max(BOUNCE_CYC,HOLD_CYC)); it decrements and never wraps.
- LFSR: advances every cycle in PRESS_B and REL_B only, and holds in all other states.
- contact is registered; R is therefore glitch-free with respect to the FSM and follows C combinationally.

Optional Feature:
- Macro: KEYPAD_EMU_BOUNCE_EN.
- Defined: behaviour exactly as above, with LFSR-driven bounce phases.
- Undefined:
  - PRESS_B and REL_B still last BOUNCE_CYC cycles, so timing is unchanged.
  - contact=1 throughout PRESS_B, and contact=0 throughout REL_B.
  - The LFSR sub-module is not instantiated.

Decomposition:
- Package keypad_pkg:
  - state enum (IDLE, PRESS_B, HELD, REL_B)
  - KEY_ROW / KEY_COL lookup constants for codes 0..11
  - NUM_ROWS=4, NUM_COLS=3
  - KEY_MAX=11
- Sub-module keypad_lfsr:
  - 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
  - Ports: CLK, RST, en, seed, out bit.

Test Plan:
- Reset with RST=1 for 2 cycles -> R=4'b0000, cmd_ready=1, busy=0, done=0, err=0.
- Bounce off, BOUNCE_CYC=4, HOLD_CYC=8, press key 5 ->
  - During HELD with C=3'b010: R=4'b0010.
  - With C=3'b001: R=0.
  - busy high for 16 cycles; done pulses at accept+17.
- Press key 0 during HELD with C=3'b111 -> R=4'b1000; press key 11 with C=3'b100 -> R=4'b1000.
- cmd_key=13 accepted -> err=1 for 1 cycle, busy stays 0, R stays 0; cmd_valid asserted mid-sequence -> ignored, no second done.
- RST asserted during HELD -> R=0, busy=0, cmd_ready=1 the next cycle; no done pulse.
- Bounce on, seed 16'hACE1 -> R toggles at least once in PRESS_B; R is stable during HELD; after completion the scanner DUT reports N=5, V=1 once.
